seq_divider32: RTL

Sequential 32-bit restoring divider: the shift-subtract counterpart to the team's shift-add sequential multiplier, occupying the DIV slot of the ALU. It accepts a dividend/divisor pair on a start pulse and iterates one quotient bit per clock for 32 clocks. It then returns quotient and remainder with a one-cycle done strobe. The FSM and datapath live in one block; there is no external control unit.

---
 rtl/seq_divider32.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seq_divider32.sv
// Sequential 32-bit restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN to enable signed division (signed_op) with a sign fix-up state.
module seq_divider32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

`ifdef DIV_SIGNED_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2, FIX = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
`endif

    function automatic logic signed [31:0] neg32(input logic signed [31:0] x);
        return -x;
    endfunction

    state_t      state, nxt;
    logic [4:0]  cnt;
    logic [63:0] rq;
    logic [31:0] d;
    logic        dbz_pend;
    logic [31:0] dvd_mag, dvs_mag;
    logic [63:0] rq_sh;
    logic [32:0] trial;

`ifdef DIV_SIGNED_EN
    logic a_neg, b_neg;
    logic neg_q, neg_r;
    assign a_neg   = signed_op & dividend[31];
    assign b_neg   = signed_op & divisor[31];
    assign dvd_mag = a_neg ? neg32(dividend) : dividend;
    assign dvs_mag = b_neg ? neg32(divisor) : divisor;
`else
    logic unused_signed_op;
    assign unused_signed_op = signed_op;
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
`endif

    assign rq_sh = {rq[62:0], 1'b0};
    assign trial = {1'b0, rq_sh[63:32]} - {1'b0, d};
    assign busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (start) nxt = (divisor == 32'd0) ? DONE : CALC;
            CALC: if (cnt == 5'd31) begin
`ifdef DIV_SIGNED_EN
                nxt = FIX;
`else
                nxt = DONE;
`endif
            end
`ifdef DIV_SIGNED_EN
            FIX:  nxt = DONE;
`endif
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Datapath and result registers; only control state and visible outputs are reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= 5'd0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            dbz_pend    <= 1'b0;
            quotient    <= 32'd0;
            remainder   <= 32'd0;
`ifdef DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cnt         <= 5'd0;
                    div_by_zero <= 1'b0;
                    dbz_pend    <= (divisor == 32'd0);
`ifdef DIV_SIGNED_EN
                    neg_q       <= a_neg ^ b_neg;
                    neg_r       <= a_neg;
`endif
                    if (divisor == 32'd0) begin
                        rq <= {dividend, 32'hFFFF_FFFF};
                    end else begin
                        rq <= {32'd0, dvd_mag};
                        d  <= dvs_mag;
                    end
                end
                CALC: begin
                    if (!trial[32]) rq <= {trial[31:0], rq_sh[31:1], 1'b1};
                    else            rq <= rq_sh;
                    cnt <= cnt + 5'd1;
                end
`ifdef DIV_SIGNED_EN
                FIX: begin
                    rq[31:0]  <= neg_q ? neg32(rq[31:0])  : rq[31:0];
                    rq[63:32] <= neg_r ? neg32(rq[63:32]) : rq[63:32];
                end
`endif
                DONE: begin
                    done        <= 1'b1;
                    quotient    <= rq[31:0];
                    remainder   <= rq[63:32];
                    div_by_zero <= dbz_pend;
                end
                default: ;
            endcase
        end
    end

endmodule
